bist_pattern_misr: RTL and testbench
====================================

Name: bist_pattern_misr

Overview:
- Self-test harness stage around a combinational benchmark netlist (28 PI / 17 PO class).
- Upstream half: LFSR pattern generator drives the netlist's primary inputs.
- Downstream half: MISR compacts the netlist's primary outputs into a signature, which is compared against a golden value.
- Used to characterise original and locked netlist variants in simulation and on FPGA.

Parameters:
- PI_W, 28, LFSR width = number of netlist primary inputs
- PO_W, 17, MISR width = number of netlist primary outputs
- LFSR_TAPS, 28'h9000000, feedback mask (x^28+x^25+1)
- LFSR_SEED, 28'h0000001, LFSR load value; 0 is replaced by 1
- MISR_TAPS, 17'h12000, feedback mask (x^17+x^14+1)
- MISR_SEED, 17'h00000, MISR load value
- CNT_W, 16, pattern counter width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run (sampled in IDLE or DONE)
- abort  in  1  return to IDLE from any state
- n_pat  in  CNT_W  number of patterns; latched on accepted start
- golden  in  PO_W  expected signature; compared combinationally against the MISR
- pi_out  out  PI_W  pattern to netlist PIs (= LFSR register)
- po_in  in  PO_W  netlist PO response to the current pi_out
- busy  out  1  high in RUN
- done  out  1  high in DONE (level)
- pass  out  1  registered signature==golden, valid while done
- signature  out  PO_W  MISR register
- pat_cnt  out  CNT_W  patterns captured so far

Behaviour:
- Reset state: IDLE, lfsr=LFSR_SEED (0 is replaced by 1), misr=MISR_SEED, cnt=0, busy=0, done=0, pass=0.
- Step functions:
  - lfsr_next = {lfsr[PI_W-2:0], ^(lfsr & LFSR_TAPS)}
  - misr_next = {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ po_in
- IDLE:
  - start=1 → load lfsr/misr seeds, cnt=0, latch n_pat.
  - Go to RUN, or directly to DONE if n_pat==0.
  - In the n_pat==0 case, pass = (MISR_SEED==golden) on that same edge.
- RUN:
  - Every edge: misr←misr_next, lfsr←lfsr_next, cnt←cnt+1.
  - po_in sampled on edge k is the response to the pattern driven since edge k-1, so the netlist has one full cycle of settle time.
  - On the edge where cnt reaches n_pat: go to DONE and register pass = (misr_next==golden).
  - busy is high for exactly n_pat cycles.
- DONE:
  - lfsr, misr and cnt are held.
  - start=1 → reload and restart, same as from IDLE.
  - done and pass are cleared on leaving DONE.
- start during RUN: ignored.
- abort: has priority over start in every state; next edge → IDLE with seeds reloaded, cnt=0, done=0, pass=0.
- golden may change at any time; only its value on the final capture edge matters.
- cnt wrap: impossible, since n_pat ≤ 2^CNT_W-1 and the run ends at n_pat.
- rst mid-run: immediately restores the reset state; no partial signature survives.

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, RUN, DONE}
  - default tap/seed constants for 28/17-bit widths
  - function lfsr_step(value, taps) for generic-width stepping
- One natural sub-module, shift_reg_lfsr: parameterised width/taps, with load/enable/data-xor inputs.
  - Instantiated twice: as the pattern LFSR (data-xor tied 0) and as the MISR (data-xor = po_in).
- Controller FSM and counter live in the top.

Test Plan:
- Small config PI_W=4, LFSR_TAPS=4'h9, seed 1, n_pat=15 → pi_out in RUN = 1,3,7,15,14,13,10,5,11,6,12,9,2,4,8; busy high 15 cycles; pat_cnt=15 at done.
- Small config PO_W=4, MISR_TAPS=4'h9, seed 0, loopback po_in=pi_out, n_pat=3, golden=4'h7 → signature 7, pass=1. Repeat with golden=4'h6 → pass=0.
- Default widths, po_in held 0, n_pat=255 → signature 0. Then inject a single-bit flip of po_in on pattern 100 → signature ≠ 0, pass=0 with golden=0.
- n_pat=0, golden=MISR_SEED → DONE one cycle after start; busy never high; pass=1.
- start pulsed during RUN at cycle 5 of 10 → no effect; done after 10 captures. Then abort in DONE → IDLE, done=0, pi_out=LFSR_SEED.
- rst asserted asynchronously mid-run (cycle 7 of 20) → outputs return to reset values without a clock edge. A new start then yields a signature identical to a clean run.

Source files
------------

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared types and constants for the BIST pattern-generator / MISR harness.
//   state_e    : controller states (IDLE, RUN, DONE)
//   DEF_*      : default widths, tap masks and seeds for a 28 PI / 17 PO netlist
//   lfsr_step  : one shift-left step of a Fibonacci LFSR of any width up to
//                STEP_MAX_W, feedback = XOR of the tapped bits
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DEF_PI_W      = 28;
  localparam int          DEF_PO_W      = 17;
  localparam int          DEF_CNT_W     = 16;
  localparam logic [27:0] DEF_LFSR_TAPS = 28'h9000000;  // x^28 + x^25 + 1
  localparam logic [27:0] DEF_LFSR_SEED = 28'h0000001;
  localparam logic [16:0] DEF_MISR_TAPS = 17'h12000;    // x^17 + x^14 + 1
  localparam logic [16:0] DEF_MISR_SEED = 17'h00000;

  localparam int STEP_MAX_W = 64;

  // Generic-width step: callers zero-extend into STEP_MAX_W bits and truncate
  // the result back to their own width; bits above width are masked off.
  function automatic logic [STEP_MAX_W-1:0] lfsr_step(
    input logic [STEP_MAX_W-1:0] value,
    input logic [STEP_MAX_W-1:0] taps,
    input int                    width
  );
    logic [STEP_MAX_W-1:0] mask;
    logic                  fb;
    mask = (STEP_MAX_W'(1) << width) - STEP_MAX_W'(1);
    fb   = ^(value & taps & mask);
    return ((value << 1) | STEP_MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/bist_pattern_misr_if.sv
// -----------------------------------------------------------------------------
// bist_pattern_misr_if
// Control, netlist and result signals of the BIST harness.
//   slave  : the harness (consumes start/abort/n_pat/golden/po_in,
//            produces pi_out/busy/done/pass/signature/pat_cnt)
//   master : the driver (controller, or testbench)
// -----------------------------------------------------------------------------
interface bist_pattern_misr_if #(
  parameter int PI_W  = 28,
  parameter int PO_W  = 17,
  parameter int CNT_W = 16
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_pat;
  logic [PO_W-1:0]  golden;
  logic [PI_W-1:0]  pi_out;
  logic [PO_W-1:0]  po_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [PO_W-1:0]  signature;
  logic [CNT_W-1:0] pat_cnt;

  modport slave (
    input  start, abort, n_pat, golden, po_in,
    output pi_out, busy, done, pass, signature, pat_cnt
  );

  modport master (
    output start, abort, n_pat, golden, po_in,
    input  pi_out, busy, done, pass, signature, pat_cnt
  );

endinterface

// File: rtl/shift_reg_lfsr.sv
// -----------------------------------------------------------------------------
// shift_reg_lfsr
// Parameterised shift-left LFSR with load, enable and a parallel data-xor input.
// With data_i tied to 0 it is a pattern generator; with data_i = response it is
// a MISR.
//   clk, rst : clock, asynchronous active-high reset (register <- SEED)
//   load_i   : reload SEED (priority over en_i)
//   en_i     : advance one step: value <- step(value) ^ data_i
//   data_i   : word folded into the register on each enabled step
//   value_o  : current register contents
// -----------------------------------------------------------------------------
module shift_reg_lfsr
  import bist_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W-1:0] TAPS = '1,
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign value_d = W'(lfsr_step(STEP_MAX_W'(value_q), STEP_MAX_W'(TAPS), W)) ^ data_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SEED;
    end else if (load_i) begin
      value_q <= SEED;
    end else if (en_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/bist_pattern_misr.sv
// -----------------------------------------------------------------------------
// bist_pattern_misr
// BIST harness around a combinational netlist: an LFSR drives the netlist
// inputs, a MISR compacts its outputs, and the final signature is compared
// against a golden value.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bist_pattern_misr_if.slave
//     start / abort        : begin a run (IDLE or DONE) / return to IDLE
//     n_pat                : patterns per run, latched on accepted start
//     golden               : expected signature, used on the final capture
//     pi_out / po_in       : pattern to netlist / netlist response
//     busy / done / pass   : in RUN / in DONE / registered signature match
//     signature / pat_cnt  : MISR contents / patterns captured so far
// -----------------------------------------------------------------------------
module bist_pattern_misr
  import bist_pkg::*;
#(
  parameter int              PI_W      = DEF_PI_W,
  parameter int              PO_W      = DEF_PO_W,
  parameter logic [PI_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [PI_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter logic [PO_W-1:0] MISR_TAPS = DEF_MISR_TAPS,
  parameter logic [PO_W-1:0] MISR_SEED = DEF_MISR_SEED,
  parameter int              CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  bist_pattern_misr_if.slave  bus
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [PI_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] n_pat_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [PI_W-1:0]  lfsr_q;
  logic [PO_W-1:0]  misr_q;
  logic [PO_W-1:0]  misr_d;
  logic             seed_load;
  logic             step_en;

  // Seeds reload on abort and on any start the controller accepts.
  assign seed_load = bus.abort || (bus.start && (state_q != RUN));
  assign step_en   = (state_q == RUN) && !bus.abort;
  assign cnt_d     = cnt_q + CNT_W'(1);

  // Value the MISR takes on this edge; needed for the final pass compare.
  assign misr_d = PO_W'(lfsr_step(STEP_MAX_W'(misr_q), STEP_MAX_W'(MISR_TAPS), PO_W))
                  ^ bus.po_in;

  shift_reg_lfsr #(
    .W    (PI_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_INIT)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_load),
    .en_i    (step_en),
    .data_i  ({PI_W{1'b0}}),
    .value_o (lfsr_q)
  );

  shift_reg_lfsr #(
    .W    (PO_W),
    .TAPS (MISR_TAPS),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_load),
    .en_i    (step_en),
    .data_i  (bus.po_in),
    .value_o (misr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_pat_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt_q   <= '0;
            n_pat_q <= bus.n_pat;
            if (bus.n_pat == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (MISR_SEED == bus.golden);
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (cnt_d == n_pat_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (misr_d == bus.golden);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pi_out    = lfsr_q;
  assign bus.signature = misr_q;
  assign bus.pat_cnt   = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_bist_pattern_misr.sv
// -----------------------------------------------------------------------------
// tb_bist_pattern_misr
// Directed bench for bist_pattern_misr. Two instances share clk/rst:
//   u_small : 4-bit LFSR and MISR, taps 4'h9
//   u_def   : default 28/17-bit configuration
// -----------------------------------------------------------------------------
module tb_bist_pattern_misr;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bist_pattern_misr_if #(.PI_W(4),  .PO_W(4),  .CNT_W(16)) s_if ();
  bist_pattern_misr_if #(.PI_W(28), .PO_W(17), .CNT_W(16)) d_if ();

  // po_in is either a driven word or the pattern looped straight back.
  logic        s_lb;
  logic [3:0]  s_po;
  logic        d_lb;
  logic [16:0] d_po;

  assign s_if.po_in = s_lb ? s_if.pi_out : s_po;
  assign d_if.po_in = d_lb ? d_if.pi_out[16:0] : d_po;

  bist_pattern_misr #(
    .PI_W(4), .PO_W(4),
    .LFSR_TAPS(4'h9), .LFSR_SEED(4'h1),
    .MISR_TAPS(4'h9), .MISR_SEED(4'h0),
    .CNT_W(16)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  bist_pattern_misr u_def (
    .clk (clk),
    .rst (rst),
    .bus (d_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference signature for the default instance with po_in = pi_out[16:0].
  function automatic logic [16:0] model_sig(input int n);
    logic [27:0] l;
    logic [16:0] m;
    l = 28'h1;
    m = 17'h0;
    for (int k = 0; k < n; k++) begin
      m = {m[15:0], m[16] ^ m[13]} ^ l[16:0];
      l = {l[26:0], l[27] ^ l[24]};
    end
    return m;
  endfunction

  task automatic test_reset();
    checks++;
    if (s_if.pi_out !== 4'h1 || s_if.signature !== 4'h0 || s_if.pat_cnt !== 16'd0 ||
        s_if.busy !== 1'b0 || s_if.done !== 1'b0 || s_if.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_small: pi=%h sig=%h cnt=%0d b/d/p=%b%b%b, need pi=1 sig=0 cnt=0 b/d/p=000",
               s_if.pi_out, s_if.signature, s_if.pat_cnt, s_if.busy, s_if.done, s_if.pass);
    end
    checks++;
    if (d_if.pi_out !== 28'h1 || d_if.signature !== 17'h0 || d_if.pat_cnt !== 16'd0 ||
        d_if.busy !== 1'b0 || d_if.done !== 1'b0 || d_if.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_def: pi=%h sig=%h cnt=%0d b/d/p=%b%b%b, need pi=1 sig=0 cnt=0 b/d/p=000",
               d_if.pi_out, d_if.signature, d_if.pat_cnt, d_if.busy, d_if.done, d_if.pass);
    end
  endtask

  task automatic test_lfsr_sequence();
    logic [3:0] exp_pi [15];
    exp_pi = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5,
               4'd11, 4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8};
    s_if.n_pat = 16'd15;
    s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (s_if.busy !== 1'b1 || s_if.pi_out !== exp_pi[i]) begin
        errors++;
        $display("FAIL lfsr_seq[%0d]: busy=%b pi=%0d, need busy=1 pi=%0d",
                 i, s_if.busy, s_if.pi_out, exp_pi[i]);
      end
      tick();
    end
    checks++;
    if (s_if.busy !== 1'b0 || s_if.done !== 1'b1 || s_if.pat_cnt !== 16'd15) begin
      errors++;
      $display("FAIL lfsr_done: busy=%b done=%b cnt=%0d, need busy=0 done=1 cnt=15",
               s_if.busy, s_if.done, s_if.pat_cnt);
    end
  endtask

  task automatic run_small_loopback(input logic [3:0] gold, input logic exp_pass);
    s_lb        = 1'b1;
    s_if.golden = gold;
    s_if.n_pat  = 16'd3;
    s_if.start  = 1'b1;
    tick();
    s_if.start = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_if.done !== 1'b1 || s_if.signature !== 4'h7 || s_if.pass !== exp_pass) begin
      errors++;
      $display("FAIL misr_loopback gold=%h: done=%b sig=%h pass=%b, need done=1 sig=7 pass=%b",
               gold, s_if.done, s_if.signature, s_if.pass, exp_pass);
    end
  endtask

  task automatic test_misr_loopback();
    run_small_loopback(4'h7, 1'b1);
    run_small_loopback(4'h6, 1'b0);
  endtask

  task automatic test_zero_response();
    d_lb        = 1'b0;
    d_po        = '0;
    d_if.golden = '0;
    d_if.n_pat  = 16'd255;
    d_if.start  = 1'b1;
    tick();
    d_if.start = 1'b0;
    repeat (255) tick();
    checks++;
    if (d_if.done !== 1'b1 || d_if.signature !== 17'h0 || d_if.pass !== 1'b1 ||
        d_if.pat_cnt !== 16'd255) begin
      errors++;
      $display("FAIL zero_resp: done=%b sig=%h pass=%b cnt=%0d, need done=1 sig=0 pass=1 cnt=255",
               d_if.done, d_if.signature, d_if.pass, d_if.pat_cnt);
    end
    // Same run, one bit flipped on the response to pattern 100.
    d_if.start = 1'b1;
    tick();
    d_if.start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      d_po = (i == 99) ? 17'h1 : 17'h0;
      tick();
    end
    d_po = '0;
    checks++;
    if (d_if.done !== 1'b1 || d_if.signature === 17'h0 || d_if.pass !== 1'b0) begin
      errors++;
      $display("FAIL bit_flip: done=%b sig=%h pass=%b, need done=1 sig!=0 pass=0",
               d_if.done, d_if.signature, d_if.pass);
    end
  endtask

  task automatic test_zero_patterns();
    int busy_seen;
    busy_seen  = 0;
    d_if.abort = 1'b1;
    tick();
    d_if.abort  = 1'b0;
    d_if.golden = 17'h0;
    d_if.n_pat  = 16'd0;
    d_if.start  = 1'b1;
    tick();
    d_if.start = 1'b0;
    if (d_if.busy) busy_seen++;
    checks++;
    if (d_if.done !== 1'b1 || d_if.pass !== 1'b1 || d_if.pat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_pat: done=%b pass=%b cnt=%0d, need done=1 pass=1 cnt=0",
               d_if.done, d_if.pass, d_if.pat_cnt);
    end
    tick();
    if (d_if.busy) busy_seen++;
    checks++;
    if (busy_seen != 0 || d_if.done !== 1'b1) begin
      errors++;
      $display("FAIL zero_pat_busy: busy cycles=%0d done=%b, need 0 and done=1",
               busy_seen, d_if.done);
    end
  endtask

  task automatic test_start_ignored();
    d_if.n_pat = 16'd10;
    d_if.start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      d_if.start = (i == 5);
      checks++;
      if (d_if.busy !== 1'b1 || d_if.pat_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL run_cycle[%0d]: busy=%b cnt=%0d, need busy=1 cnt=%0d",
                 i, d_if.busy, d_if.pat_cnt, i);
      end
      tick();
    end
    d_if.start = 1'b0;
    checks++;
    if (d_if.done !== 1'b1 || d_if.busy !== 1'b0 || d_if.pat_cnt !== 16'd10) begin
      errors++;
      $display("FAIL start_ignored: done=%b busy=%b cnt=%0d, need done=1 busy=0 cnt=10",
               d_if.done, d_if.busy, d_if.pat_cnt);
    end
    // abort outranks a simultaneous start.
    d_if.abort = 1'b1;
    d_if.start = 1'b1;
    tick();
    d_if.abort = 1'b0;
    d_if.start = 1'b0;
    tick();
    checks++;
    if (d_if.done !== 1'b0 || d_if.busy !== 1'b0 || d_if.pass !== 1'b0 ||
        d_if.pi_out !== 28'h1 || d_if.pat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort: done=%b busy=%b pass=%b pi=%h cnt=%0d, need 0 0 0 pi=1 cnt=0",
               d_if.done, d_if.busy, d_if.pass, d_if.pi_out, d_if.pat_cnt);
    end
  endtask

  task automatic run_def_loopback(input int n);
    d_lb        = 1'b1;
    d_if.golden = model_sig(n);
    d_if.n_pat  = 16'(n);
    d_if.start  = 1'b1;
    tick();
    d_if.start = 1'b0;
    repeat (n) tick();
    checks++;
    if (d_if.done !== 1'b1 || d_if.signature !== model_sig(n) || d_if.pass !== 1'b1) begin
      errors++;
      $display("FAIL loopback_%0d: done=%b sig=%h pass=%b, need done=1 sig=%h pass=1",
               n, d_if.done, d_if.signature, d_if.pass, model_sig(n));
    end
  endtask

  task automatic test_async_reset();
    run_def_loopback(20);
    d_if.n_pat = 16'd20;
    d_if.start = 1'b1;
    tick();
    d_if.start = 1'b0;
    repeat (7) tick();
    // Reset pulse lies entirely between clock edges.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d_if.busy !== 1'b0 || d_if.done !== 1'b0 || d_if.pass !== 1'b0 ||
        d_if.pat_cnt !== 16'd0 || d_if.signature !== 17'h0 || d_if.pi_out !== 28'h1) begin
      errors++;
      $display("FAIL async_rst: b/d/p=%b%b%b cnt=%0d sig=%h pi=%h, need 000 cnt=0 sig=0 pi=1",
               d_if.busy, d_if.done, d_if.pass, d_if.pat_cnt, d_if.signature, d_if.pi_out);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    run_def_loopback(20);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    s_lb       = 1'b0;
    s_po       = '0;
    d_lb       = 1'b0;
    d_po       = '0;
    s_if.start = 1'b0;
    s_if.abort = 1'b0;
    s_if.n_pat = '0;
    s_if.golden = '0;
    d_if.start = 1'b0;
    d_if.abort = 1'b0;
    d_if.n_pat = '0;
    d_if.golden = '0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_lfsr_sequence();
    test_misr_loopback();
    test_zero_response();
    test_zero_patterns();
    test_start_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
